seg7_scan_decoder: RTL

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder.sv | 114 +++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: debounced decoder for a multiplexed active-low 7-segment scan; optional err_count via SEG7_DEC_ERRCNT_EN
module seg7_scan_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              seg_in,
    input  logic [2:0]              dig_sel,
    input  logic                    seg_valid,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_ok,
    output logic                    upd,
    output logic [2:0]              upd_idx,
    output logic                    err
`ifdef SEG7_DEC_ERRCNT_EN
    ,
    output logic [7:0]              err_count
`endif
);
    localparam logic [6:0] BLANK  = 7'h7f;
    localparam logic [3:0] STABLE = 4'(STABLE_CNT);
    logic [6:0] cand [NUM_DIGITS];
    logic [3:0] cnt  [NUM_DIGITS];
    logic [4:0] dec;
    logic [6:0] sel_cand;
    logic [3:0] sel_cnt;
    logic [3:0] nxt_cnt;
    logic       in_range;
    logic       err_nxt;
    logic       commit;
    // pattern decode: {valid, hex value}; blank stays invalid so it can never match a candidate
    always_comb begin
        dec = 5'h00;
        case (seg_in)
            7'h40: dec = 5'h10;
            7'h79: dec = 5'h11;
            7'h24: dec = 5'h12;
            7'h30: dec = 5'h13;
            7'h19: dec = 5'h14;
            7'h12: dec = 5'h15;
            7'h02: dec = 5'h16;
            7'h78: dec = 5'h17;
            7'h00: dec = 5'h18;
            7'h10: dec = 5'h19;
            7'h08: dec = 5'h1a;
            7'h03: dec = 5'h1b;
            7'h46: dec = 5'h1c;
            7'h21: dec = 5'h1d;
            7'h06: dec = 5'h1e;
            7'h0e: dec = 5'h1f;
            default: dec = 5'h00;
        endcase
    end
    // select the addressed digit's candidate and compute its next match count
    always_comb begin
        sel_cand = BLANK;
        sel_cnt  = 4'd0;
        for (int d = 0; d < NUM_DIGITS; d++)
            if (dig_sel == 3'(d)) begin
                sel_cand = cand[d];
                sel_cnt  = cnt[d];
            end
        nxt_cnt  = (sel_cand == seg_in) ? ((sel_cnt == STABLE) ? sel_cnt : sel_cnt + 4'd1) : 4'd1;
        in_range = int'(dig_sel) < NUM_DIGITS;
        err_nxt  = seg_valid && (!in_range || !dec[4]);
        commit   = seg_valid && in_range && dec[4] && (nxt_cnt == STABLE);
    end
    // per-digit candidate tracking, commit and registered pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits   <= '0;
            digit_ok <= '0;
            upd      <= 1'b0;
            upd_idx  <= 3'd0;
            err      <= 1'b0;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                cand[d] <= BLANK;
                cnt[d]  <= 4'd0;
            end
        end else begin
            err <= err_nxt;
            upd <= 1'b0;
            for (int d = 0; d < NUM_DIGITS; d++)
                if (seg_valid && dig_sel == 3'(d)) begin
                    if (!dec[4]) begin
                        cand[d]     <= BLANK;
                        cnt[d]      <= 4'd0;
                        digit_ok[d] <= 1'b0;
                    end else begin
                        cand[d] <= seg_in;
                        cnt[d]  <= nxt_cnt;
                        if (commit) begin
                            digits[4*d +: 4] <= dec[3:0];
                            digit_ok[d]      <= 1'b1;
                            if (digits[4*d +: 4] != dec[3:0] || !digit_ok[d]) begin
                                upd     <= 1'b1;
                                upd_idx <= 3'(d);
                            end
                        end
                    end
                end
        end
    end
`ifdef SEG7_DEC_ERRCNT_EN
    // saturating count of error pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_count <= 8'd0;
        else if (err_nxt && err_count != 8'hff)
            err_count <= err_count + 8'd1;
    end
`endif
endmodule
